core_mgmt_mailbox_slave: RTL and testbench
==========================================

// Module: core_mgmt_mailbox_slave
// PURPOSE
//  AXI4-Lite responder in core_management; the far end of each core's write-back master channel.
//  Accepts single-beat writes of {wb_rd, wb_rd_data} records and queues them in a mailbox FIFO.
//  Serves reads: pop the mailbox head, or return status. Raises mb_irq while the mailbox is non-empty.
// PARAMETERS
//  BASE_ADDR   32'h8800_0000  Slave base; writes must hit BASE_ADDR+OFS_DATA, else SLVERR.
//  FIFO_DEPTH  8              Mailbox entries; power of 2, >=2.
// PORTS
//  clk         in   1   Clock; all logic on posedge.
//  rst         in   1   Asynchronous, active-high reset.
//  s_awvalid   in   1   Write address valid.
//  s_awready   out  1   Write address ready.
//  s_awaddr    in   32  Write address.
//  s_wvalid    in   1   Write data valid.
//  s_wready    out  1   Write data ready.
//  s_wdata     in   32  Write data (record payload).
//  s_bvalid    out  1   Write response valid.
//  s_bready    in   1   Write response ready.
//  s_bresp     out  2   00 OKAY, 10 SLVERR.
//  s_arvalid   in   1   Read address valid.
//  s_arready   out  1   Read address ready.
//  s_araddr    in   32  Read address.
//  s_rvalid    out  1   Read data valid.
//  s_rready    in   1   Read data ready.
//  s_rdata     out  32  Read data.
//  s_rresp     out  2   00 OKAY, 10 SLVERR.
//  mb_count    out  $clog2(FIFO_DEPTH)+1  Current occupancy.
//  mb_irq      out  1   Registered; high while mb_count != 0.
// BEHAVIOUR
//  Reset: all ready/valid outputs 0; bresp/rresp/rdata 0; FIFO empty; overflow 0; both FSMs idle.
//  Reset mid-transaction: the transaction is abandoned; no response is issued.
//  Write FSM: W_IDLE -> W_RESP -> W_IDLE.
//   - W_IDLE: s_awready = s_wready = !full. AW and W are captured independently (either order, or same cycle).
//   - When both are held: addr == BASE_ADDR+OFS_DATA -> push {awaddr, wdata} and set bresp OKAY;
//     any other addr -> no push and bresp SLVERR. Then enter W_RESP with s_bvalid=1 on the next cycle.
//   - W_RESP: hold bvalid/bresp until s_bready; then return to W_IDLE. Ready stays 0 in W_RESP.
//   - Full: awready/wready stay low (backpressure; nothing is dropped). Overflow is not reachable via AXI.
//  Read FSM: R_IDLE -> R_RESP -> R_IDLE. s_arready=1 only in R_IDLE.
//   - Capture araddr; drive rvalid on the next cycle; hold it until s_rready.
//   - OFS_DATA: if non-empty, rdata = head data, rresp OKAY, pop head at the AR-handshake edge.
//     If empty: rdata 0, rresp SLVERR, no pop.
//   - OFS_ADDR: rdata = head's captured awaddr; no pop; 0 if empty.
//   - OFS_STAT: rdata = {empty, full, 22'b0, count zero-extended to 8 bits}.
//   - Other offsets: rdata 0, rresp SLVERR.
//  Same-cycle push and pop: occupancy unchanged. Pop-when-empty uses pre-push state, so it still returns SLVERR.
//  Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from registered count, not pointer compare.
//  Latency: write handshake -> bvalid +1 cycle; AR handshake -> rvalid +1 cycle; push -> mb_irq +1 cycle.
// STRUCTURE
//  Package core_mgmt_mailbox_pkg holds:
//   - OFS_DATA=0x0, OFS_ADDR=0x4, OFS_STAT=0x8;
//   - RESP_OKAY/RESP_SLVERR;
//   - mailbox_entry_t {addr[31:0], data[31:0]};
//   - write/read FSM state enums.
//  Sub-module mailbox_fifo: sync FIFO of mailbox_entry_t with push/pop/full/empty/count. The top holds the two FSMs.
// TESTING
//  1 Reset: assert rst async mid-cycle -> all outputs 0, mb_count=0, mb_irq=0 immediately.
//  2 Write 0xDEAD_BEEF to BASE+0 (AW one cycle before W) -> bvalid next cycle, OKAY; mb_count=1, mb_irq=1.
//    Then read BASE+0 -> rdata 0xDEAD_BEEF, OKAY; mb_count=0.
//  3 Fill 8 entries 1..8 -> 9th write sees awready=0 until one read.
//    Reads return 1..8 in order; the 9th read returns SLVERR with rdata 0.
//  4 Write to BASE+0x10 -> bresp SLVERR, mb_count unchanged. Read BASE+0x8 after 3 pushes -> rdata 0x0000_0003.
//  5 bready held low 5 cycles -> bvalid/bresp stable, awready=0 throughout.
//    rready low 5 cycles -> rdata stable, exactly one pop.
//  6 With count=1, read BASE+0 in the same cycle the write pushes -> rdata = old head, count stays 1.
//    Then empty -> pop concurrent with push returns SLVERR, count=1.

Source files
------------

// File: rtl/core_mgmt_mailbox_pkg.sv
// Shared types and constants for the core-management mailbox slave:
// register offsets, AXI response codes, FIFO entry record and FSM states.
package core_mgmt_mailbox_pkg;

    localparam logic [31:0] OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] OFS_ADDR = 32'h0000_0004;
    localparam logic [31:0] OFS_STAT = 32'h0000_0008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } mailbox_entry_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/core_mgmt_mailbox_slave_fifo.sv
// Synchronous mailbox FIFO of mailbox_entry_t records.
// Ports: clk, rst (async high), push/push_entry, pop/head, full, empty, count.
module mailbox_fifo
    import core_mgmt_mailbox_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  mailbox_entry_t push_entry,
    input  logic           pop,
    output mailbox_entry_t head,
    output logic           full,
    output logic           empty,
    output logic [CW-1:0]  count
);

    mailbox_entry_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Full/empty are taken from the occupancy register so that the
    // pointers may simply wrap without an extra lap bit.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/core_mgmt_mailbox_slave.sv
// AXI4-Lite mailbox responder: queues write-back records, serves pops/status.
// Ports: clk, rst, AXI-Lite slave s_aw*/s_w*/s_b*/s_ar*/s_r*, mb_count, mb_irq.
module core_mgmt_mailbox_slave
    import core_mgmt_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8800_0000,
    parameter int FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_awvalid,
    output logic          s_awready,
    input  logic [31:0]   s_awaddr,
    input  logic          s_wvalid,
    output logic          s_wready,
    input  logic [31:0]   s_wdata,
    output logic          s_bvalid,
    input  logic          s_bready,
    output logic [1:0]    s_bresp,
    input  logic          s_arvalid,
    output logic          s_arready,
    input  logic [31:0]   s_araddr,
    output logic          s_rvalid,
    input  logic          s_rready,
    output logic [31:0]   s_rdata,
    output logic [1:0]    s_rresp,
    output logic [CW-1:0] mb_count,
    output logic          mb_irq
);

    wr_state_t      wstate;
    rd_state_t      rstate;
    logic           up;
    logic           aw_held;
    logic           w_held;
    logic [31:0]    awaddr_q;
    logic [31:0]    wdata_q;
    logic           full;
    logic           empty;
    mailbox_entry_t head;
    mailbox_entry_t wr_entry;
    logic           aw_hs;
    logic           w_hs;
    logic           ar_hs;
    logic           wr_go;
    logic           addr_ok;
    logic           push;
    logic           pop;
    logic           pop_hit;
    logic [31:0]    rd_data_nxt;
    logic [1:0]     rd_resp_nxt;
    logic [CW-1:0]  cnt_nxt;

    // 'up' is cleared by reset, so every ready is low while rst is high.
    assign s_awready = up && (wstate == W_IDLE) && !aw_held && !full;
    assign s_wready  = up && (wstate == W_IDLE) && !w_held && !full;
    assign s_arready = up && (rstate == R_IDLE);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // A channel is usable either from its holding register or live.
    assign wr_entry.addr = aw_held ? awaddr_q : s_awaddr;
    assign wr_entry.data = w_held ? wdata_q : s_wdata;
    assign wr_go   = (wstate == W_IDLE) && (aw_held || aw_hs)
                     && (w_held || w_hs);
    assign addr_ok = (wr_entry.addr == BASE_ADDR + OFS_DATA);
    assign push    = wr_go && addr_ok && !full;
    assign pop     = ar_hs && pop_hit;
    assign cnt_nxt = mb_count + CW'(push) - CW'(pop);

    // Read decode sees the pre-push FIFO state, so a pop racing a push
    // into an empty mailbox still reports SLVERR.
    always_comb begin
        rd_data_nxt = '0;
        rd_resp_nxt = RESP_OKAY;
        pop_hit     = 1'b0;
        case (s_araddr)
            BASE_ADDR + OFS_DATA: begin
                if (empty) begin
                    rd_resp_nxt = RESP_SLVERR;
                end else begin
                    rd_data_nxt = head.data;
                    pop_hit     = 1'b1;
                end
            end
            BASE_ADDR + OFS_ADDR: begin
                if (!empty) begin
                    rd_data_nxt = head.addr;
                end
            end
            BASE_ADDR + OFS_STAT: begin
                rd_data_nxt = {empty, full, 22'b0, 8'(mb_count)};
            end
            default: begin
                rd_resp_nxt = RESP_SLVERR;
            end
        endcase
    end

    mailbox_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (mb_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up     <= 1'b0;
            mb_irq <= 1'b0;
        end else begin
            up     <= 1'b1;
            mb_irq <= (cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate   <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (wr_go) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= addr_ok ? RESP_OKAY : RESP_SLVERR;
                        wstate   <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            awaddr_q <= s_awaddr;
                        end
                        if (w_hs) begin
                            w_held  <= 1'b1;
                            wdata_q <= s_wdata;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        wstate   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate   <= R_IDLE;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_rvalid <= 1'b1;
                        s_rdata  <= rd_data_nxt;
                        s_rresp  <= rd_resp_nxt;
                        rstate   <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        rstate   <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mgmt_mailbox_slave.sv
// Directed self-checking bench for core_mgmt_mailbox_slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_core_mgmt_mailbox_slave;

    localparam logic [31:0] BASE = 32'h8800_0000;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_awaddr = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [31:0] s_wdata = '0;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [3:0]  mb_count;
    logic        mb_irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_mgmt_mailbox_slave #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .mb_count  (mb_count),
        .mb_irq    (mb_irq)
    );

    // One AXI write; lat counts falling edges from last handshake to bvalid.
    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input bit aw_first, input int hold,
                      output logic [1:0] resp, output int lat,
                      output bit stable);
        bit awd, wd, ha, hw;
        awd = 0; wd = 0; stable = 1; lat = 0; resp = 2'b11;
        s_awvalid = 1'b1; s_awaddr = a;
        if (!aw_first) begin s_wvalid = 1'b1; s_wdata = d; end
        for (int i = 0; i < 50 && !(awd && wd); i++) begin
            ha = s_awvalid && s_awready;
            hw = s_wvalid && s_wready;
            @(negedge clk);
            if (ha) begin awd = 1; s_awvalid = 1'b0; end
            if (hw) begin wd = 1; s_wvalid = 1'b0; end
            if (awd && !wd && !s_wvalid) begin
                s_wvalid = 1'b1; s_wdata = d;
            end
        end
        if (!(awd && wd)) begin
            n_cmp++; n_err++;
            $display("FAIL wr_handshake_timeout: aw=%0b w=%0b required 1 1", awd, wd);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        while (!s_bvalid && lat < 20) begin @(negedge clk); lat++; end
        if (!s_bvalid) begin
            n_cmp++; n_err++;
            $display("FAIL wr_bvalid_timeout: bvalid=0 required 1");
            return;
        end
        resp = s_bresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!s_bvalid || s_bresp !== resp || s_awready !== 1'b0) stable = 0;
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    // One AXI read; lat counts falling edges from AR handshake to rvalid.
    task automatic rd(input logic [31:0] a, input int hold,
                      output logic [31:0] data, output logic [1:0] resp,
                      output int lat, output bit stable);
        bit ard, h;
        ard = 0; stable = 1; lat = 0; data = 'x; resp = 2'b11;
        s_arvalid = 1'b1; s_araddr = a;
        for (int i = 0; i < 50 && !ard; i++) begin
            h = s_arvalid && s_arready;
            @(negedge clk);
            if (h) begin ard = 1; s_arvalid = 1'b0; end
        end
        if (!ard) begin
            n_cmp++; n_err++;
            $display("FAIL rd_handshake_timeout: arready never seen, required 1");
            s_arvalid = 1'b0;
            return;
        end
        while (!s_rvalid && lat < 20) begin @(negedge clk); lat++; end
        if (!s_rvalid) begin
            n_cmp++; n_err++;
            $display("FAIL rd_rvalid_timeout: rvalid=0 required 1");
            return;
        end
        data = s_rdata; resp = s_rresp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!s_rvalid || s_rdata !== data || s_rresp !== resp
                || s_arready !== 1'b0) stable = 0;
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    // Write to BASE+0 and read BASE+0 handshaking on the same clock edge.
    task automatic conc(input logic [31:0] d, output bit rdy_ok,
                        output bit both_valid, output logic [31:0] rdata,
                        output logic [1:0] rresp, output logic [1:0] bresp);
        s_awvalid = 1'b1; s_awaddr = BASE;
        s_wvalid = 1'b1; s_wdata = d;
        s_arvalid = 1'b1; s_araddr = BASE;
        rdy_ok = s_awready && s_wready && s_arready;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        both_valid = s_bvalid && s_rvalid;
        rdata = s_rdata; rresp = s_rresp; bresp = s_bresp;
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] flags;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_held_ready: got %b required 00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b required 111",
                     {s_awready, s_wready, s_arready});
        end
        s_awvalid = 1'b1; s_awaddr = BASE;
        s_wvalid = 1'b1; s_wdata = 32'h0000_00A5;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_cmp++;
        if ({s_bvalid, mb_count, mb_irq} !== {1'b1, 4'd1, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset_write: bvalid/count/irq got %b required 1_0001_1",
                     {s_bvalid, mb_count, mb_irq});
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        flags = {s_awready, s_wready, s_bvalid, s_bresp, s_arready,
                 s_rvalid, mb_irq, 1'b0};
        n_cmp++;
        if (flags !== 9'b0 || s_rresp !== 2'b0) begin
            n_err++;
            $display("FAIL async_reset_flags: got %b rresp %b required all 0",
                     flags, s_rresp);
        end
        n_cmp++;
        if (s_rdata !== 32'h0 || mb_count !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset_data: rdata %h count %0d required 0 0",
                     s_rdata, mb_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (s_bvalid !== 1'b0 || mb_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_abandon: bvalid %b count %0d required 0 0",
                     s_bvalid, mb_count);
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp;
        logic [31:0] data;
        int lat;
        bit st;
        wr(BASE, 32'hDEAD_BEEF, 1'b1, 0, resp, lat, st);
        n_cmp++;
        if (resp !== OKAY || lat !== 0) begin
            n_err++;
            $display("FAIL basic_write: bresp %b lat %0d required 00 0", resp, lat);
        end
        n_cmp++;
        if (mb_count !== 4'd1 || mb_irq !== 1'b1) begin
            n_err++;
            $display("FAIL basic_count: count %0d irq %b required 1 1",
                     mb_count, mb_irq);
        end
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'hDEAD_BEEF || resp !== OKAY || lat !== 0) begin
            n_err++;
            $display("FAIL basic_read: rdata %h rresp %b lat %0d required deadbeef 00 0",
                     data, resp, lat);
        end
        n_cmp++;
        if (mb_count !== 4'd0 || mb_irq !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain: count %0d irq %b required 0 0",
                     mb_count, mb_irq);
        end
    endtask

    task automatic test_fill();
        logic [1:0] resp;
        logic [31:0] data;
        int lat;
        bit st, blocked;
        for (int i = 1; i <= 8; i++) begin
            wr(BASE, 32'(i), 1'b0, 0, resp, lat, st);
            n_cmp++;
            if (resp !== OKAY) begin
                n_err++;
                $display("FAIL fill_write_%0d: bresp %b required 00", i, resp);
            end
        end
        n_cmp++;
        if (mb_count !== 4'd8) begin
            n_err++;
            $display("FAIL fill_count: count %0d required 8", mb_count);
        end
        blocked = 1;
        s_awvalid = 1'b1; s_awaddr = BASE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_awready !== 1'b0 || s_wready !== 1'b0) blocked = 0;
        end
        s_awvalid = 1'b0;
        n_cmp++;
        if (!blocked) begin
            n_err++;
            $display("FAIL full_backpressure: ready seen 1 required 0");
        end
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'd1 || s_awready !== 1'b1) begin
            n_err++;
            $display("FAIL full_release: rdata %0d awready %b required 1 1",
                     data, s_awready);
        end
        for (int i = 2; i <= 8; i++) begin
            rd(BASE, 0, data, resp, lat, st);
            n_cmp++;
            if (data !== 32'(i) || resp !== OKAY) begin
                n_err++;
                $display("FAIL fill_order_%0d: rdata %0d rresp %b required %0d 00",
                         i, data, resp, i);
            end
        end
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h0 || resp !== SLVERR || mb_count !== 4'd0) begin
            n_err++;
            $display("FAIL empty_pop: rdata %h rresp %b count %0d required 0 10 0",
                     data, resp, mb_count);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        logic [31:0] data;
        int lat;
        bit st;
        wr(BASE + 32'h10, 32'h1234_5678, 1'b0, 0, resp, lat, st);
        n_cmp++;
        if (resp !== SLVERR || mb_count !== 4'd0) begin
            n_err++;
            $display("FAIL bad_wr_addr: bresp %b count %0d required 10 0",
                     resp, mb_count);
        end
        wr(BASE, 32'h11, 1'b0, 0, resp, lat, st);
        wr(BASE, 32'h22, 1'b1, 0, resp, lat, st);
        wr(BASE, 32'h33, 1'b0, 0, resp, lat, st);
        rd(BASE + 32'h8, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h0000_0003 || resp !== OKAY) begin
            n_err++;
            $display("FAIL stat_read: rdata %h rresp %b required 00000003 00",
                     data, resp);
        end
        rd(BASE + 32'h4, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== BASE || resp !== OKAY) begin
            n_err++;
            $display("FAIL addr_read: rdata %h rresp %b required %h 00",
                     data, resp, BASE);
        end
        rd(BASE + 32'hC, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h0 || resp !== SLVERR || mb_count !== 4'd3) begin
            n_err++;
            $display("FAIL bad_rd_addr: rdata %h rresp %b count %0d required 0 10 3",
                     data, resp, mb_count);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        logic [31:0] data;
        int lat;
        bit st;
        wr(BASE, 32'h44, 1'b0, 5, resp, lat, st);
        n_cmp++;
        if (!st || resp !== OKAY || mb_count !== 4'd4) begin
            n_err++;
            $display("FAIL bready_hold: stable %b bresp %b count %0d required 1 00 4",
                     st, resp, mb_count);
        end
        rd(BASE, 5, data, resp, lat, st);
        n_cmp++;
        if (!st || data !== 32'h11 || mb_count !== 4'd3) begin
            n_err++;
            $display("FAIL rready_hold: stable %b rdata %h count %0d required 1 11 3",
                     st, data, mb_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp, bresp;
        logic [31:0] data;
        int lat;
        bit st, rdy, bv;
        rd(BASE, 0, data, resp, lat, st);
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h33 || mb_count !== 4'd1) begin
            n_err++;
            $display("FAIL b2b_setup: rdata %h count %0d required 33 1",
                     data, mb_count);
        end
        conc(32'h55, rdy, bv, data, resp, bresp);
        n_cmp++;
        if (!rdy || !bv || data !== 32'h44 || resp !== OKAY || bresp !== OKAY) begin
            n_err++;
            $display("FAIL push_pop_same: rdy %b valid %b rdata %h rresp %b bresp %b required 1 1 44 00 00",
                     rdy, bv, data, resp, bresp);
        end
        n_cmp++;
        if (mb_count !== 4'd1 || mb_irq !== 1'b1) begin
            n_err++;
            $display("FAIL push_pop_count: count %0d irq %b required 1 1",
                     mb_count, mb_irq);
        end
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h55 || mb_count !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_new_head: rdata %h count %0d required 55 0",
                     data, mb_count);
        end
        conc(32'h66, rdy, bv, data, resp, bresp);
        n_cmp++;
        if (!rdy || !bv || data !== 32'h0 || resp !== SLVERR || bresp !== OKAY) begin
            n_err++;
            $display("FAIL empty_push_pop: rdy %b valid %b rdata %h rresp %b bresp %b required 1 1 0 10 00",
                     rdy, bv, data, resp, bresp);
        end
        n_cmp++;
        if (mb_count !== 4'd1 || mb_irq !== 1'b1) begin
            n_err++;
            $display("FAIL empty_push_pop_count: count %0d irq %b required 1 1",
                     mb_count, mb_irq);
        end
        rd(BASE, 0, data, resp, lat, st);
        n_cmp++;
        if (data !== 32'h66 || mb_count !== 4'd0 || mb_irq !== 1'b0) begin
            n_err++;
            $display("FAIL final_drain: rdata %h count %0d irq %b required 66 0 0",
                     data, mb_count, mb_irq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_errors();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
